// File: rtl/exec_sequencer.sv
// BRISC instruction-phase sequencer: one-cycle reg_en / pc_en strobes in the CLK domain.
// Define EXEC_SEQ_STEP_EN to compile in the single-step button path.
module exec_sequencer #(
  parameter int unsigned BASE_PERIOD = 50000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        load_done,
  input  logic        run,
  input  logic [2:0]  speed,
  input  logic        step_btn,
  output logic        reg_en,
  output logic        pc_en,
  output logic [1:0]  state,
  output logic        running,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    LOAD = 2'b00,
    IDLE = 2'b01,
    EXEC = 2'b10,
    ADV  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic             step_mode_r;
  logic [CNT_W-1:0] prescaler_r;
  logic [CNT_W-1:0] shifted_s;
  logic [CNT_W-1:0] period_s;
  logic             terminal_s;
  logic             step_pulse_s;

  assign state = state_r;

`ifdef EXEC_SEQ_STEP_EN
  logic sync1_r;
  logic sync2_r;
  logic step_pulse_r;

  // Button synchronizer and rising-edge detect; a held button gives one pulse.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_r      <= 1'b0;
      sync2_r      <= 1'b0;
      step_pulse_r <= 1'b0;
    end else begin
      sync1_r      <= step_btn;
      sync2_r      <= sync1_r;
      step_pulse_r <= sync1_r & ~sync2_r;
    end
  end

  assign step_pulse_s = step_pulse_r;
`else
  logic step_btn_unused_s;
  assign step_btn_unused_s = step_btn;
  assign step_pulse_s      = 1'b0;
`endif

  // Phase length from the speed switches; a lowered period ends a running phase at once.
  always_comb begin
    shifted_s = CNT_W'(BASE_PERIOD) >> speed;
    if (shifted_s == {CNT_W{1'b0}}) begin
      period_s = CNT_ONE;
    end else begin
      period_s = shifted_s;
    end
    terminal_s = (prescaler_r >= (period_s - CNT_ONE));
  end

  // Sequencer FSM with registered strobes, running flag and instruction counter.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r     <= LOAD;
      step_mode_r <= 1'b0;
      prescaler_r <= {CNT_W{1'b0}};
      reg_en      <= 1'b0;
      pc_en       <= 1'b0;
      running     <= 1'b0;
      instr_count <= 16'h0000;
    end else begin
      reg_en <= 1'b0;
      pc_en  <= 1'b0;
      if (!load_done) begin
        state_r     <= LOAD;
        step_mode_r <= 1'b0;
        prescaler_r <= {CNT_W{1'b0}};
        running     <= 1'b0;
      end else begin
        case (state_r)
          LOAD: begin
            state_r     <= IDLE;
            prescaler_r <= {CNT_W{1'b0}};
            running     <= 1'b0;
          end
          IDLE: begin
            prescaler_r <= {CNT_W{1'b0}};
            if (run) begin
              state_r     <= EXEC;
              step_mode_r <= 1'b0;
              running     <= 1'b1;
            end else if (step_pulse_s) begin
              state_r     <= EXEC;
              step_mode_r <= 1'b1;
              running     <= 1'b1;
            end else begin
              state_r <= IDLE;
              running <= 1'b0;
            end
          end
          EXEC: begin
            if (step_mode_r || (run && terminal_s)) begin
              state_r     <= ADV;
              reg_en      <= 1'b1;
              prescaler_r <= {CNT_W{1'b0}};
              running     <= 1'b1;
            end else if (!run) begin
              state_r     <= IDLE;
              prescaler_r <= {CNT_W{1'b0}};
              running     <= 1'b0;
            end else begin
              prescaler_r <= prescaler_r + CNT_ONE;
              running     <= 1'b1;
            end
          end
          ADV: begin
            // The instruction always completes here, even if run has dropped.
            if (step_mode_r || terminal_s) begin
              pc_en       <= 1'b1;
              instr_count <= instr_count + 16'h0001;
              prescaler_r <= {CNT_W{1'b0}};
              if (run && !step_mode_r) begin
                state_r <= EXEC;
                running <= 1'b1;
              end else begin
                state_r <= IDLE;
                running <= 1'b0;
              end
            end else begin
              prescaler_r <= prescaler_r + CNT_ONE;
              running     <= 1'b1;
            end
          end
          default: begin
            state_r     <= LOAD;
            step_mode_r <= 1'b0;
            prescaler_r <= {CNT_W{1'b0}};
            running     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
